// File: rtl/ternary_matmul_sequencer.sv
// Purpose: control FSM for one ternary systolic-array tile (clear, feed, drain, snapshot, read out).
// Latency: start -> first out_valid = 1 + k_len*SLICES + SLICES cycles; done follows ARRAY_SIZE-1 cycles later.
// Backpressure: none; the array cannot stall, so a missing in_valid beat aborts the tile and sets sticky err.
// Optional build macro SEQ_BACK_TO_BACK_EN: a start on the done cycle chains straight into the next tile.
module ternary_matmul_sequencer #(
    parameter int SLICES     = 2,
    parameter int ARRAY_SIZE = 4 * SLICES * SLICES,
    parameter int K_BITS     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [K_BITS-1:0]             k_len,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          array_restart_inputs,
    output logic                          array_reset_acc,
    output logic                          array_copy_out,
    output logic                          array_restart_out,
    output logic                          out_valid,
    output logic [$clog2(ARRAY_SIZE)-1:0] out_index,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam int IDX_W  = $clog2(ARRAY_SIZE);
    // Sized so k_len = 2^K_BITS-1 times SLICES beats cannot wrap.
    localparam int BEAT_W = K_BITS + $clog2(SLICES);
    localparam int FL_W   = $clog2(SLICES + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ARRAY_SIZE - 1);
    localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(SLICES - 1);

`ifdef SEQ_BACK_TO_BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        FLUSH,
        READ
    } state_t;

    state_t              state;
    logic [K_BITS-1:0]   k_q;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [BEAT_W-1:0]   beat_last;
    logic [FL_W-1:0]     flush_cnt;

    // Index of the final input beat of the tile (only meaningful when k_q != 0).
    always_comb begin
        beat_last = BEAT_W'(k_q) * BEAT_W'(SLICES) - BEAT_W'(1);
    end

    // Tile state machine; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                <= IDLE;
            k_q                  <= '0;
            beat_cnt             <= '0;
            flush_cnt            <= '0;
            in_ready             <= 1'b0;
            out_valid            <= 1'b0;
            out_index            <= '0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            err                  <= 1'b0;
            array_restart_inputs <= 1'b1;
            array_reset_acc      <= 1'b1;
            array_restart_out    <= 1'b1;
            array_copy_out       <= 1'b0;
        end else begin
            done           <= 1'b0;
            array_copy_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        k_q                  <= k_len;
                        err                  <= 1'b0;
                        state                <= CLEAR;
                        busy                 <= 1'b1;
                        array_restart_inputs <= 1'b1;
                        array_reset_acc      <= 1'b1;
                        array_restart_out    <= 1'b0;
                    end
                end
                CLEAR: begin
                    array_restart_inputs <= 1'b0;
                    array_reset_acc      <= 1'b0;
                    array_restart_out    <= 1'b0;
                    if (k_q != '0) begin
                        state    <= FEED;
                        beat_cnt <= '0;
                        in_ready <= 1'b1;
                    end else begin
                        state             <= FLUSH;
                        flush_cnt         <= '0;
                        array_copy_out    <= (FL_LAST == '0);
                        array_restart_out <= (FL_LAST == '0);
                    end
                end
                FEED: begin
                    if (!in_valid) begin
                        // Underrun: the array has already advanced, so the tile is unrecoverable.
                        state                <= IDLE;
                        err                  <= 1'b1;
                        in_ready             <= 1'b0;
                        busy                 <= 1'b0;
                        array_restart_inputs <= 1'b1;
                        array_reset_acc      <= 1'b1;
                        array_restart_out    <= 1'b1;
                    end else if (beat_cnt == beat_last) begin
                        state             <= FLUSH;
                        in_ready          <= 1'b0;
                        flush_cnt         <= '0;
                        array_copy_out    <= (FL_LAST == '0);
                        array_restart_out <= (FL_LAST == '0);
                    end else begin
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                    end
                end
                FLUSH: begin
                    if (flush_cnt == FL_LAST) begin
                        state             <= READ;
                        array_restart_out <= 1'b0;
                        array_reset_acc   <= 1'b1;
                        out_valid         <= 1'b1;
                        out_index         <= '0;
                        done              <= (IDX_LAST == '0);
                    end else begin
                        // Copy lands on the last drain cycle so the final slice is captured.
                        flush_cnt         <= flush_cnt + FL_W'(1);
                        array_copy_out    <= (flush_cnt + FL_W'(1) == FL_LAST);
                        array_restart_out <= (flush_cnt + FL_W'(1) == FL_LAST);
                    end
                end
                READ: begin
                    if (out_index == IDX_LAST) begin
                        out_valid <= 1'b0;
                        out_index <= '0;
                        if (B2B && start) begin
                            k_q                  <= k_len;
                            err                  <= 1'b0;
                            state                <= CLEAR;
                            array_restart_inputs <= 1'b1;
                            array_reset_acc      <= 1'b1;
                            array_restart_out    <= 1'b0;
                        end else begin
                            state                <= IDLE;
                            busy                 <= 1'b0;
                            array_restart_inputs <= 1'b1;
                            array_reset_acc      <= 1'b1;
                            array_restart_out    <= 1'b1;
                        end
                    end else begin
                        out_index <= out_index + IDX_W'(1);
                        done      <= (out_index + IDX_W'(1) == IDX_LAST);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ternary_matmul_sequencer.sv
// Bench for ternary_matmul_sequencer: table-driven tiles, random tiles, chaining and mid-tile reset.
// Expected per-cycle outputs come from a timeline model of the tile (cycle offsets from start).
// Cycle t means the t-th clock after the edge that sampled start.
module tb_ternary_matmul_sequencer;

    localparam int S  = 2;
    localparam int AS = 4 * S * S;

`ifdef SEQ_BACK_TO_BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] k_len;
    logic       in_valid;
    logic       in_ready;
    logic       array_restart_inputs;
    logic       array_reset_acc;
    logic       array_copy_out;
    logic       array_restart_out;
    logic       out_valid;
    logic [3:0] out_index;
    logic       busy;
    logic       done;
    logic       err;

    ternary_matmul_sequencer #(.SLICES(S), .K_BITS(8)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start                (start),
        .k_len                (k_len),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .array_restart_inputs (array_restart_inputs),
        .array_reset_acc      (array_reset_acc),
        .array_copy_out       (array_copy_out),
        .array_restart_out    (array_restart_out),
        .out_valid            (out_valid),
        .out_index            (out_index),
        .busy                 (busy),
        .done                 (done),
        .err                  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       in_ready;
        logic       ri;
        logic       ra;
        logic       copy;
        logic       ro;
        logic       ov;
        logic [3:0] idx;
        logic       busy;
        logic       done;
        logic       err;
    } obs_t;

    typedef struct {
        int k;
        int drop;
        bit noise;
        int exp_copy;
        int exp_done;
        bit exp_err;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t observe();
        obs_t o;
        o = {in_ready, array_restart_inputs, array_reset_acc, array_copy_out,
             array_restart_out, out_valid, out_index, busy, done, err};
        return o;
    endfunction

    function automatic obs_t idle_obs(input bit e);
        obs_t o;
        o      = '0;
        o.ri   = 1'b1;
        o.ra   = 1'b1;
        o.ro   = 1'b1;
        o.err  = e;
        return o;
    endfunction

    // Timeline model: CLEAR at 1, FEED for k*S cycles, FLUSH for S cycles, READ for AS cycles.
    function automatic obs_t model(input int t, input int k, input int drop);
        obs_t o;
        int   fs;
        int   r0;
        fs = 2 + k * S;
        r0 = fs + S;
        o  = '0;
        if (drop >= 0 && t > 2 + drop) return idle_obs(1'b1);
        if (t >= r0 + AS) return idle_obs(1'b0);
        o.busy = 1'b1;
        if (t == 1) begin
            o.ri = 1'b1;
            o.ra = 1'b1;
        end else if (t < fs) begin
            o.in_ready = 1'b1;
        end else if (t < r0) begin
            o.copy = (t == r0 - 1);
            o.ro   = (t == r0 - 1);
        end else begin
            o.ov   = 1'b1;
            o.idx  = 4'(t - r0);
            o.ra   = 1'b1;
            o.done = (t == r0 + AS - 1);
        end
        return o;
    endfunction

    task automatic check_obs(input string name, input int cyc, input obs_t g, input obs_t e);
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%b want=%b (in_ready,restart_in,reset_acc,copy,restart_out,out_valid,out_index,busy,done,err)",
                     name, cyc, g, e);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Runs one tile from the idle cycle before start (or from cycle 1 if already started).
    task automatic run_tile(input int k, input int drop, input bit noise, input int chain_k,
                            input bit skip_start, output int copy_c, output int done_c,
                            output bit err_f);
        int   len;
        obs_t g;
        obs_t e;
        len    = (drop >= 0) ? 3 + drop : 2 + k * S + S + AS;
        copy_c = 0;
        done_c = 0;
        err_f  = 1'b0;
        for (int t = (skip_start ? 1 : 0); t < len; t++) begin
            if (t == 0) begin
                start = 1'b1;
                k_len = 8'(k);
            end else if (t == len - 1 && chain_k >= 0) begin
                start = 1'b1;
                k_len = 8'(chain_k);
            end else begin
                start = (noise && t < len - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                k_len = 8'($urandom);
            end
            if (t >= 2 && t < 2 + k * S) in_valid = (t - 2 != drop);
            else                         in_valid = 1'($urandom_range(0, 1));
            step();
            g = observe();
            if (t + 1 == len && chain_k >= 0) e = B2B ? model(1, chain_k, -1) : idle_obs(1'b0);
            else                              e = model(t + 1, k, drop);
            check_obs("tile", t + 1, g, e);
            if (g.copy && copy_c == 0) copy_c = t + 1;
            if (g.done && done_c == 0) done_c = t + 1;
            err_f = g.err;
        end
        start = 1'b0;
    endtask

    vec_t vecs[6];

    initial begin
        int   cc;
        int   dc;
        bit   ef;
        int   k;
        int   drop;
        obs_t g;

        vecs[0] = '{k: 3,   drop: -1, noise: 1'b0, exp_copy: 9,   exp_done: 25,  exp_err: 1'b0};
        vecs[1] = '{k: 0,   drop: -1, noise: 1'b1, exp_copy: 3,   exp_done: 19,  exp_err: 1'b0};
        vecs[2] = '{k: 4,   drop: 5,  noise: 1'b0, exp_copy: 0,   exp_done: 0,   exp_err: 1'b1};
        vecs[3] = '{k: 1,   drop: -1, noise: 1'b1, exp_copy: 5,   exp_done: 21,  exp_err: 1'b0};
        vecs[4] = '{k: 255, drop: -1, noise: 1'b0, exp_copy: 513, exp_done: 529, exp_err: 1'b0};
        vecs[5] = '{k: 2,   drop: 0,  noise: 1'b1, exp_copy: 0,   exp_done: 0,   exp_err: 1'b1};

        rst_n    = 1'b0;
        start    = 1'b0;
        k_len    = '0;
        in_valid = 1'b0;
        step();
        check_obs("reset_state", 0, observe(), idle_obs(1'b0));
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_obs("idle_after_reset", i, observe(), idle_obs(1'b0));
        end

        // Directed tiles with hand-derived copy/done cycles.
        for (int i = 0; i < 6; i++) begin
            run_tile(vecs[i].k, vecs[i].drop, vecs[i].noise, -1, 1'b0, cc, dc, ef);
            check_int($sformatf("vec%0d_copy_cycle", i), cc, vecs[i].exp_copy);
            check_int($sformatf("vec%0d_done_cycle", i), dc, vecs[i].exp_done);
            check_int($sformatf("vec%0d_err", i), int'(ef), int'(vecs[i].exp_err));
        end

        // Random tiles, some with underruns, with start/k_len noise while busy.
        for (int i = 0; i < 25; i++) begin
            k    = $urandom_range(0, 5);
            drop = (k > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, k * S - 1) : -1;
            run_tile(k, drop, 1'b1, -1, 1'b0, cc, dc, ef);
        end

        // start on the done cycle: chained tile when enabled, otherwise ignored.
        run_tile(2, -1, 1'b0, 1, 1'b0, cc, dc, ef);
        if (B2B) run_tile(1, -1, 1'b0, -1, 1'b1, cc, dc, ef);
        else     run_tile(1, -1, 1'b0, -1, 1'b0, cc, dc, ef);
        check_int("chained_tile_done_cycle", dc, 21);

        // Reset during READ at out_index 7 aborts with no done; start held in reset is dropped.
        start    = 1'b1;
        k_len    = 8'd1;
        in_valid = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 13; c++) step();
        g = observe();
        check_obs("pre_reset_read_idx7", 13, g, model(13, 1, -1));
        rst_n = 1'b0;
        start = 1'b1;
        step();
        check_obs("reset_abort", 14, observe(), idle_obs(1'b0));
        step();
        check_obs("reset_hold_start", 15, observe(), idle_obs(1'b0));
        rst_n = 1'b1;
        start = 1'b0;
        step();
        check_obs("after_reset_idle", 16, observe(), idle_obs(1'b0));
        step();
        check_obs("after_reset_idle2", 17, observe(), idle_obs(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ternary_matmul_sequencer.md
Name: ternary_matmul_sequencer

Overview:
- Control FSM for the ternary systolic array.
- Runs one tile: clears the array, streams k_len input vectors of SLICES beats each, waits for the MAC pipeline to drain, snapshots accumulators into the out queue, then reads out ARRAY_SIZE bytes.
- Sits between the top-level IO wrapper and the systolic array, and drives all four array control strobes.

Parameters:
- SLICES, 2, input beats per vector; also the array drain latency in cycles.
- ARRAY_SIZE, 4*SLICES*SLICES (16), number of accumulators read out per tile.
- K_BITS, 8, width of the vector-count input.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  start a tile; sampled only in IDLE
- k_len  in  K_BITS  vectors in tile; latched at start
- in_valid  in  1  host has a weight/activation beat on array inputs this cycle
- in_ready  out  1  sequencer is consuming array inputs this cycle
- array_restart_inputs  out  1  to array restart_inputs
- array_reset_acc  out  1  to array reset_accumulators
- array_copy_out  out  1  to array copy_accumulator_values_to_out_queue
- array_restart_out  out  1  to array restart_out_queue
- out_valid  out  1  array out byte is valid result
- out_index  out  $clog2(ARRAY_SIZE)  accumulator index of current out byte
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on last readout beat
- err  out  1  sticky underrun flag; cleared by next accepted start

Behaviour:
- Clock is clk; reset is rst_n, synchronous, active-low. Reset has priority over every other input.
- All outputs are registered.
- Reset values: state=IDLE; in_ready=0; out_valid=0; out_index=0; busy=0; done=0; err=0; array_restart_inputs=1; array_reset_acc=1; array_restart_out=1; array_copy_out=0.
- Reset asserted mid-tile aborts immediately to these values; no done pulse.
- IDLE:
  - Array strobes held as in reset.
  - start=1 latches k_len, clears err, and moves to CLEAR.
- CLEAR (1 cycle):
  - restart_inputs=1, reset_acc=1, copy=0, restart_out=0.
  - Next state is FEED if k_len!=0, otherwise FLUSH.
- FEED (k_len*SLICES cycles):
  - in_ready=1; strobes all 0.
  - A beat counter counts 0..k_len*SLICES-1.
  - The array cannot stall, so a cycle with in_valid=0 is an underrun: set err=1, go to IDLE, no readout, no done.
  - After the last beat, go to FLUSH.
  - The beat counter is K_BITS+$clog2(SLICES) bits wide and must not overflow for k_len=2^K_BITS-1.
- FLUSH (SLICES cycles):
  - in_ready=0.
  - On the final FLUSH cycle, assert array_copy_out=1 and array_restart_out=1. The copy captures the array's next-state accumulators, so the last slice is included.
  - Then go to READ.
- READ (ARRAY_SIZE cycles):
  - out_valid=1; out_index runs 0..ARRAY_SIZE-1, tracking the array's free-running out-queue counter.
  - array_reset_acc=1 throughout READ. The out queue is already captured, and the next tile starts clean.
  - On index ARRAY_SIZE-1: done=1, then go to IDLE.
- start while busy is ignored; k_len changes after start are ignored.
- Latency, start to first out_valid: 1 (CLEAR) + k_len*SLICES + SLICES cycles.
- Latency, start to done: the above plus ARRAY_SIZE-1 cycles.
- k_len=0 yields an all-zero readout with the normal done pulse.

Optional Feature:
- Macro SEQ_BACK_TO_BACK_EN.
- Defined: start=1 on the done cycle latches the new k_len and goes directly to CLEAR, skipping IDLE (zero idle gap between tiles). busy stays 1. err is cleared as for a normal start.
- Undefined: the sequencer always returns to IDLE for at least one cycle, and start on the done cycle is ignored.

Test Plan:
- Reset then idle 5 cycles -> busy=0, strobes restart_inputs=1, reset_acc=1, restart_out=1, copy=0; out_valid=0.
- start with k_len=3, in_valid held 1 -> CLEAR 1 cycle, in_ready high 6 cycles, copy pulse on cycle 9 after start, out_valid for 16 cycles with out_index 0..15, done on index 15.
- start with k_len=0 -> no in_ready, copy 2 cycles after CLEAR, 16 readout beats, done pulse.
- start with k_len=4, drop in_valid on beat 5 -> err=1 next cycle, busy=0, no out_valid, no done. A new start clears err.
- Assert rst_n=0 during READ at out_index=7 -> next cycle all outputs at reset values. start held during reset is not taken.
- SEQ_BACK_TO_BACK_EN defined, start=1 on done cycle with k_len=1 -> next cycle in CLEAR, busy stays 1. Undefined -> one IDLE cycle, second start required.
